drive_cmd_arbiter: RTL
======================

// Module: drive_cmd_arbiter
// PURPOSE
//  Parametrised N-source motion-command arbiter; successor to the fixed 3-way mux in the car top level.
//  Picks the highest-priority enabled source (bluetooth, ultrasonic, infrared, ...) and registers its command.
//  Holds the last command for HOLD_CYCLES after the source releases.
//  Inserts a STOP brake window on direction reversal.
//  Output ctr drives the PWM motor block directly.
// PARAMETERS
//  N_SRC        3   number of command sources; index 0 = highest priority
//  CMD_W        3   command width
//  SEL_W        2   width of sel_idx, >= ceil(log2(N_SRC))
//  CNT_W        24  hold/brake counter width; must hold max(HOLD_CYCLES,BRAKE_CYCLES)
//  HOLD_CYCLES  1000000  cycles last command is held after all sources drop (0 = no hold)
//  BRAKE_CYCLES 500000   STOP cycles inserted on FWD<->BACK reversal (0 = no brake)
// PORTS
//  clk       in   1              system clock
//  reset     in   1              asynchronous, active-high reset
//  src_en    in   N_SRC          per-source request
//  src_cmd   in   N_SRC*CMD_W    flattened commands; source i at [i*CMD_W +: CMD_W]
//  src_mask  in   N_SRC          1 = source allowed; masked sources are treated as not enabled
//  ctr       out  CMD_W          registered command to PWM block
//  sel_idx   out  SEL_W          index of source currently owning ctr
//  active    out  1              1 in DRIVE/HOLD/BRAKE
//  hold      out  1              1 in HOLD
//  brake     out  1              1 in BRAKE
//  sw_pulse  out  1              one-cycle pulse when owning source index changes
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ctr=CMD_STOP, sel_idx=0, cnt=0, active/hold/brake/sw_pulse=0.
//  Request vector: req = src_en & src_mask; winner = lowest set index of req, combinational; wcmd = its command.
//  All outputs are registered: 1-cycle latency from inputs to ctr.
//  Reversal: rev(a,b) is true iff {a,b} = {CMD_FWD,CMD_BACK}.
//  IDLE:
//   - req != 0 -> DRIVE; ctr<=wcmd; sel_idx<=winner; sw_pulse iff winner != sel_idx.
//  DRIVE (each cycle):
//   - req != 0, rev(ctr,wcmd), BRAKE_CYCLES>0 -> BRAKE; ctr<=STOP; cnt<=BRAKE_CYCLES-1.
//   - req != 0, otherwise -> stay; ctr<=wcmd; sel_idx<=winner; sw_pulse on index change.
//   - req == 0, HOLD_CYCLES>0 -> HOLD; ctr unchanged; cnt<=HOLD_CYCLES-1.
//   - req == 0, HOLD_CYCLES==0 -> IDLE; ctr<=STOP.
//  HOLD:
//   - req != 0 -> evaluated exactly as DRIVE against the held ctr, so a reversal enters BRAKE.
//   - req == 0, cnt==0 -> IDLE; ctr<=STOP; sel_idx unchanged.
//   - req == 0, cnt>0 -> cnt<=cnt-1.
//  BRAKE:
//   - ctr=STOP throughout; input changes ignored until exit.
//   - cnt>0 -> cnt<=cnt-1.
//   - cnt==0, req != 0 -> DRIVE; ctr<=wcmd sampled that cycle; no reversal check from STOP.
//   - cnt==0, req == 0 -> IDLE.
//   - sel_idx<=winner on exit; sw_pulse if changed.
//  Flags are decoded from the registered state:
//   - active = state != IDLE
//   - hold   = state == HOLD
//   - brake  = state == BRAKE
//  Counter never wraps; it only decrements while nonzero.
//  Simultaneous higher-priority arrival and current-source drop in one cycle: winner switches directly, no HOLD.
// STRUCTURE
//  Shared header drive_cmd_pkg.vh:
//   - CMD_STOP=0, CMD_FWD=1, CMD_BACK=2, CMD_LEFT=3, CMD_RIGHT=4
//   - state encodings ST_IDLE/ST_DRIVE/ST_HOLD/ST_BRAKE
//  Sub-module src_prio_encoder (N_SRC, SEL_W): req -> winner index + any.
//  Top FSM, counter and output registers live in this file.
// TESTING (N_SRC=3, HOLD_CYCLES=4, BRAKE_CYCLES=3, mask=3'b111)
//  1 Priority: en=110, cmd1=LEFT, cmd2=RIGHT
//    -> next cycle ctr=3, sel_idx=1, sw_pulse=1.
//    Then en=111, cmd0=FWD -> ctr=1, sel_idx=0, sw_pulse=1 for exactly 1 cycle.
//  2 Hold: src1 FWD then en=000
//    -> ctr=FWD and hold=1 for 4 cycles, then ctr=0, active=0.
//  3 Reversal: src0 FWD, then cmd0=BACK
//    -> ctr=0 and brake=1 for 3 cycles, then ctr=2, brake=0.
//  4 Reversal from HOLD: FWD held, en=100 with cmd2=BACK during hold
//    -> BRAKE 3 cycles, then ctr=BACK, sel_idx=2.
//  5 Mask: en=011, mask=110, cmd0=FWD, cmd1=RIGHT
//    -> ctr=4, sel_idx=1; source 0 never granted.
//  6 Reset mid-BRAKE: assert reset between edges
//    -> ctr=0, all flags 0 immediately.
//    After release with en=000, block stays IDLE.

Source files
------------

// File: rtl/drive_cmd_arbiter_pkg.sv
// Shared command codes, FSM state encoding and the reversal helper
// used by the drive command arbiter.
package drive_cmd_arbiter_pkg;

  localparam int unsigned CMD_STOP  = 0;
  localparam int unsigned CMD_FWD   = 1;
  localparam int unsigned CMD_BACK  = 2;
  localparam int unsigned CMD_LEFT  = 3;
  localparam int unsigned CMD_RIGHT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_BRAKE = 2'd3
  } state_t;

  // True only for a FWD<->BACK swap in either direction.
  function automatic logic is_rev(input int unsigned a, input int unsigned b);
    return ((a == CMD_FWD) && (b == CMD_BACK)) || ((a == CMD_BACK) && (b == CMD_FWD));
  endfunction

endpackage

// File: rtl/src_prio_encoder.sv
// Fixed-priority encoder: lowest set request index wins; reports whether any request is set.
module src_prio_encoder #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_SRC-1:0] req,
  output logic [SEL_W-1:0] winner_c,
  output logic             any_c
);

  always_comb begin
    logic found;
    found    = 1'b0;
    winner_c = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[i] && !found) begin
        winner_c = SEL_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/drive_cmd_arbiter.sv
// N-source motion-command arbiter with post-release hold and a STOP brake
// window on FWD<->BACK reversal; ctr feeds the PWM motor block directly.
module drive_cmd_arbiter
  import drive_cmd_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC        = 3,
  parameter int unsigned CMD_W        = 3,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned HOLD_CYCLES  = 1000000,
  parameter int unsigned BRAKE_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       src_en,
  input  logic [N_SRC*CMD_W-1:0] src_cmd,
  input  logic [N_SRC-1:0]       src_mask,
  output logic [CMD_W-1:0]       ctr,
  output logic [SEL_W-1:0]       sel_idx,
  output logic                   active,
  output logic                   hold,
  output logic                   brake,
  output logic                   sw_pulse
);

  localparam logic [CMD_W-1:0] STOP_CMD  = CMD_W'(CMD_STOP);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BRK_LOAD  = CNT_W'(BRAKE_CYCLES - 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [CMD_W-1:0]   ctr_d;
  logic [SEL_W-1:0]   sel_d;
  logic               pulse_d;

  logic [N_SRC-1:0]   req;
  logic [SEL_W-1:0]   winner;
  logic               any;
  logic [CMD_W-1:0]   wcmd;
  logic               reversal;

  assign req = src_en & src_mask;

  src_prio_encoder #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_prio (
    .req      (req),
    .winner_c (winner),
    .any_c    (any)
  );

  // Select the winning source's command slice.
  always_comb begin
    wcmd = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (winner == SEL_W'(i)) wcmd = src_cmd[i*CMD_W +: CMD_W];
    end
  end

  assign reversal = is_rev(32'(ctr), 32'(wcmd));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ctr      <= STOP_CMD;
      sel_idx  <= '0;
      sw_pulse <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ctr      <= ctr_d;
      sel_idx  <= sel_d;
      sw_pulse <= pulse_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ctr_d   = ctr;
    sel_d   = sel_idx;
    pulse_d = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_DRIVE;
          ctr_d   = wcmd;
          sel_d   = winner;
          pulse_d = (winner != sel_idx);
        end
      end
      ST_DRIVE, ST_HOLD: begin
        // HOLD re-arbitrates against the held ctr, so a reversal still brakes.
        if (any) begin
          if (reversal && (BRAKE_CYCLES > 0)) begin
            state_d = ST_BRAKE;
            ctr_d   = STOP_CMD;
            cnt_d   = BRK_LOAD;
          end else begin
            state_d = ST_DRIVE;
            ctr_d   = wcmd;
            sel_d   = winner;
            pulse_d = (winner != sel_idx);
          end
        end else if (state == ST_DRIVE) begin
          if (HOLD_CYCLES > 0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = ST_IDLE;
            ctr_d   = STOP_CMD;
          end
        end else if (cnt == '0) begin
          state_d = ST_IDLE;
          ctr_d   = STOP_CMD;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_BRAKE: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          state_d = any ? ST_DRIVE : ST_IDLE;
          ctr_d   = any ? wcmd : STOP_CMD;
          sel_d   = winner;
          pulse_d = (winner != sel_idx);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags decode straight from the registered state.
  always_comb begin
    active = (state != ST_IDLE);
    hold   = (state == ST_HOLD);
    brake  = (state == ST_BRAKE);
  end

endmodule
